// File: rtl/ecc_encode_top.sv
// rtl/ecc_encode_top.sv - page ECC encoder: 256 data words in, 256 data + 32 interleaved parity words out
module ecc_encode_top #(
  parameter int DATA_WORDS = 256,
  parameter int PAR_WORDS  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ecc_encode_req,
  input  logic        wr_en,
  input  logic [31:0] data_in,
  input  logic        rd_en,
  output logic        ecc_encode_rdy,
  output logic [31:0] data_out,
  output logic        ecc_encode_over,
  output logic        encode_output_over
);

  localparam int WW = $clog2(DATA_WORDS);
  localparam int RW = $clog2(DATA_WORDS + PAR_WORDS);
  localparam int PW = $clog2(PAR_WORDS);
  localparam logic [WW-1:0] WR_LAST = WW'(DATA_WORDS - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(DATA_WORDS + PAR_WORDS - 1);
  localparam logic [RW-1:0] RD_PAR  = RW'(DATA_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

  state_t        state, next_state;
  logic [WW-1:0] wr_ptr;
  logic [RW-1:0] rd_ptr;
  logic [31:0]   page_buf [DATA_WORDS];
  logic [31:0]   par      [PAR_WORDS];
  logic          do_start, do_write, do_read, last_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state      = state;
    do_start        = 1'b0;
    do_write        = 1'b0;
    do_read         = 1'b0;
    last_read       = 1'b0;
    ecc_encode_rdy  = 1'b0;
    ecc_encode_over = 1'b0;
    case (state)
      IDLE: begin
        if (ecc_encode_req) begin
          do_start   = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        ecc_encode_rdy = 1'b1;
        do_write       = wr_en;
        if (wr_en && wr_ptr == WR_LAST) next_state = OUT;
      end
      OUT: begin
        ecc_encode_over = 1'b1;
        do_read         = rd_en;
        if (rd_en && rd_ptr == RD_LAST) begin
          last_read  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Parity words sit after the data, so the low rd_ptr bits select the parity lane directly.
  always_comb begin
    data_out = '0;
    if (state == OUT) begin
      if (rd_ptr < RD_PAR) data_out = page_buf[rd_ptr[WW-1:0]];
      else                 data_out = par[rd_ptr[PW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      encode_output_over <= 1'b0;
      for (int k = 0; k < PAR_WORDS; k++) par[k] <= '0;
    end else begin
      encode_output_over <= last_read;
      if (do_start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        for (int k = 0; k < PAR_WORDS; k++) par[k] <= '0;
      end
      if (do_write) begin
        wr_ptr                <= wr_ptr + 1'b1;
        par[wr_ptr[PW-1:0]]   <= par[wr_ptr[PW-1:0]] ^ data_in;
      end
      if (do_read) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Page storage needs no reset; every word is rewritten before it can be read.
  always_ff @(posedge clk) begin
    if (do_write) page_buf[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_ecc_encode_top.sv
// tb/tb_ecc_encode_top.sv - directed scoreboard bench for ecc_encode_top
module tb_ecc_encode_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ecc_encode_req;
  logic        wr_en;
  logic [31:0] data_in;
  logic        rd_en;
  logic        ecc_encode_rdy;
  logic [31:0] data_out;
  logic        ecc_encode_over;
  logic        encode_output_over;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] pg    [256];
  logic [31:0] mpar  [32];

  ecc_encode_top #(.DATA_WORDS(256), .PAR_WORDS(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ecc_encode_req     (ecc_encode_req),
    .wr_en              (wr_en),
    .data_in            (data_in),
    .rd_en              (rd_en),
    .ecc_encode_rdy     (ecc_encode_rdy),
    .data_out           (data_out),
    .ecc_encode_over    (ecc_encode_over),
    .encode_output_over (encode_output_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writes pg[] as one page; optional random gaps carry ignored rd_en/req pulses.
  task automatic load_page(input bit gaps);
    for (int k = 0; k < 32; k++) mpar[k] = '0;
    ecc_encode_req = 1'b1;
    step();
    ecc_encode_req = 1'b0;
    chk("rdy_after_req", {31'b0, ecc_encode_rdy}, 32'd1);
    chk("eoo_after_req", {31'b0, encode_output_over}, 32'd0);
    for (int j = 0; j < 256; j++) begin
      if (gaps) begin
        automatic int g = $urandom_range(0, 2);
        for (int s = 0; s < g; s++) begin
          wr_en          = 1'b0;
          rd_en          = 1'b1;
          ecc_encode_req = 1'b1;
          data_in        = $urandom;
          step();
          rd_en          = 1'b0;
          ecc_encode_req = 1'b0;
          chk("over_in_stall", {31'b0, ecc_encode_over}, 32'd0);
        end
      end
      chk("rdy_load", {31'b0, ecc_encode_rdy}, 32'd1);
      wr_en   = 1'b1;
      data_in = pg[j];
      exp_q.push_back(pg[j]);
      mpar[j % 32] ^= pg[j];
      step();
      wr_en   = 1'b0;
      data_in = $urandom;
    end
    for (int k = 0; k < 32; k++) exp_q.push_back(mpar[k]);
    chk("rdy_after_load", {31'b0, ecc_encode_rdy}, 32'd0);
    chk("over_after_load", {31'b0, ecc_encode_over}, 32'd1);
  endtask

  // Drains the scoreboard; b2b leaves the pulse cycle for the caller's next req.
  task automatic read_page(input bit gaps, input bit b2b);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      if (gaps) begin
        automatic int g = $urandom_range(0, 2);
        for (int s = 0; s < g; s++) begin
          rd_en          = 1'b0;
          wr_en          = 1'b1;
          ecc_encode_req = 1'b1;
          data_in        = $urandom;
          step();
          wr_en          = 1'b0;
          ecc_encode_req = 1'b0;
          chk("out_hold", data_out, exp_q[0]);
        end
      end
      chk("over_out", {31'b0, ecc_encode_over}, 32'd1);
      chk($sformatf("word%0d", n), data_out, exp_q.pop_front());
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      n++;
    end
    chk("over_drop", {31'b0, ecc_encode_over}, 32'd0);
    chk("eoo_pulse", {31'b0, encode_output_over}, 32'd1);
    chk("data_out_idle", data_out, 32'd0);
    if (!b2b) begin
      step();
      chk("eoo_drop", {31'b0, encode_output_over}, 32'd0);
      chk("rdy_idle", {31'b0, ecc_encode_rdy}, 32'd0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ecc_encode_req = 1'b0;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    data_in        = '0;
    #1;
    chk("rst_rdy", {31'b0, ecc_encode_rdy}, 32'd0);
    chk("rst_over", {31'b0, ecc_encode_over}, 32'd0);
    chk("rst_eoo", {31'b0, encode_output_over}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // counting page, gap-free: also the latency check
    for (int j = 0; j < 256; j++) pg[j] = 32'(j);
    load_page(1'b0);
    read_page(1'b0, 1'b0);

    // single hit at word 37
    for (int j = 0; j < 256; j++) pg[j] = '0;
    pg[37] = 32'hA5A5_A5A5;
    load_page(1'b0);
    read_page(1'b0, 1'b0);

    // random data with stalls and ignored strobes
    for (int j = 0; j < 256; j++) pg[j] = $urandom;
    load_page(1'b1);
    read_page(1'b1, 1'b0);

    // back-to-back: req during the pulse cycle
    for (int j = 0; j < 256; j++) pg[j] = $urandom;
    load_page(1'b0);
    read_page(1'b0, 1'b1);
    for (int j = 0; j < 256; j++) pg[j] = 32'(j * 7 + 3);
    load_page(1'b0);
    read_page(1'b0, 1'b0);

    // reset after 100 writes, then an all-ones page
    ecc_encode_req = 1'b1;
    step();
    ecc_encode_req = 1'b0;
    for (int j = 0; j < 100; j++) begin
      wr_en   = 1'b1;
      data_in = $urandom;
      step();
    end
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", {31'b0, ecc_encode_rdy}, 32'd0);
    chk("midrst_over", {31'b0, ecc_encode_over}, 32'd0);
    chk("midrst_eoo", {31'b0, encode_output_over}, 32'd0);
    chk("midrst_data", data_out, 32'd0);
    step();
    step();
    chk("midrst_hold_rdy", {31'b0, ecc_encode_rdy}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("postrst_rdy", {31'b0, ecc_encode_rdy}, 32'd0);
    for (int j = 0; j < 256; j++) pg[j] = 32'hFFFF_FFFF;
    load_page(1'b0);
    read_page(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_encode_top.md
# ecc_encode_top

Page-level ECC encoder for the NAND write path: accepts an 8192-bit page as 256 32-bit words from the host side and appends 1024 bits of interleaved parity. It then streams the resulting 9216-bit codeword, 288 words, toward the flash interface. It is the write-direction counterpart of the page decoder and uses the same 256-data-word / 32-parity-word framing.

## Interface
- DATA_WORDS, 256, data words per page (8192 bits).
- PAR_WORDS, 32, parity words per page (1024 bits); must be a power of two dividing DATA_WORDS.
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ecc_encode_req  input  1  start request; sampled only in IDLE.
- wr_en  input  1  write strobe; data_in captured when high in LOAD.
- data_in  input  32  page data word.
- rd_en  input  1  read strobe; advances output pointer when high in OUT.
- ecc_encode_rdy  output  1  high in LOAD: block accepts data words.
- data_out  output  32  current codeword word in OUT; 0 otherwise.
- ecc_encode_over  output  1  high in OUT: codeword available.
- encode_output_over  output  1  one-cycle pulse after final codeword word read.

## Operation
- States: IDLE, LOAD, OUT.
- IDLE:
  - ecc_encode_req=1 -> LOAD next cycle.
  - On that transition wr_ptr=0, rd_ptr=0, and all 32 parity registers clear to 0.
- LOAD (rdy=1):
  - Each cycle with wr_en=1: buf[wr_ptr]=data_in; par[wr_ptr mod 32] ^= data_in; wr_ptr++.
  - wr_en=0 stalls; gaps are allowed.
  - Write with wr_ptr=255 -> OUT next cycle. The final parity update lands on the same edge.
- OUT (over=1):
  - data_out = buf[rd_ptr] for rd_ptr 0..255, par[rd_ptr-256] for rd_ptr 256..287. Combinational from the registers.
  - rd_en=1 -> rd_ptr++.
  - rd_en=1 with rd_ptr=287 -> IDLE next cycle; encode_output_over=1 for exactly that one cycle.
- Parity rule: par[k] = XOR of buf[j] over all j with j mod 32 == k. Bitwise, no carries.
- Pointers: wr_ptr 8 bits, rd_ptr 9 bits. Neither ever wraps inside a page.
- Ignored inputs:
  - ecc_encode_req outside IDLE.
  - wr_en outside LOAD.
  - rd_en outside OUT.
  - data_in when wr_en=0.
- Simultaneous req/wr_en/rd_en: only the input valid for the current state acts.
- No abort: once in LOAD, the only exits are 256 writes or reset.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE; wr_ptr, rd_ptr and all par registers 0.
  - Outputs rdy=0, over=0, encode_output_over=0, data_out=0.
  - buf contents are don't-care.
- req high at edge N: rdy=1 from after edge N. The first write may occur at edge N+1.
- 256th write at edge M: rdy=0 and over=1 after edge M. data_out=buf[0] in the same cycle. Encode latency is 0 extra cycles.
- Each rd_en edge exposes the next word immediately after that edge.
- 288th rd_en at edge R: over=0 and encode_output_over=1 after R; pulse drops after R+1.
  - req may be high during the pulse cycle and is accepted; the next LOAD follows.
- Minimum page cycle: 1 (req) + 256 + 288 = 545 cycles.
- Reset mid-LOAD or mid-OUT: return to IDLE at once, discard the page, no encode_output_over pulse.

## Test plan
- Counting page: data_in=j for j=0..255, rd_en continuous -> words 0..255 read back as 0..255, parity words 256..287 all 0x00000000, encode_output_over one cycle after word 287.
- Single hit: all data 0 except word 37=0xA5A5A5A5 -> par[5]=0xA5A5A5A5 (output word 261), all other parity words 0.
- Stall/ignore: random gaps in wr_en and rd_en; rd_en pulsed during LOAD; wr_en pulsed during OUT; req during LOAD -> same output as the gap-free run, exactly 256 writes and 288 reads counted.
- Latency check: req at cycle 0, writes at cycles 1..256 -> rdy=1 cycles 1..256, over=1 from cycle 257, data_out=word 0 in cycle 257.
- Back-to-back: req asserted during the encode_output_over cycle -> rdy=1 the next cycle; second page parity is independent of first (all parity cleared).
- Reset mid-op: rst_n low after 100 writes, then a fresh page of 0xFFFFFFFF words -> all parity 0, no stale data, all outputs 0 during reset.
